// File: rtl/hyper_pc_if.sv
// Fetch/redirect bus between hyper_pc_unit, instruction memory and decode.
// With HYPER_PC_IRQ_EN defined, it also carries irq, irq_vec and irq_ack.
interface hyper_pc_if #(
    parameter int PC_W = 16,
    parameter int SP_W = 2
);
    logic            fetch_ready;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] pc_out;
    logic            pc_valid;
    logic [SP_W:0]   stack_cnt;
    logic            ovf;
    logic            unf;
`ifdef HYPER_PC_IRQ_EN
    logic            irq;
    logic [PC_W-1:0] irq_vec;
    logic            irq_ack;
`endif

    // master: the PC unit driving fetch requests; slave: memory/decode side
    modport master (
        input  fetch_ready, br_taken, br_target, call, ret,
`ifdef HYPER_PC_IRQ_EN
        input  irq, irq_vec,
        output irq_ack,
`endif
        output pc_out, pc_valid, stack_cnt, ovf, unf
    );

    modport slave (
        output fetch_ready, br_taken, br_target, call, ret,
`ifdef HYPER_PC_IRQ_EN
        output irq, irq_vec,
        input  irq_ack,
`endif
        input  pc_out, pc_valid, stack_cnt, ovf, unf
    );
endinterface

// File: rtl/hyper_pc_unit.sv
// Program counter / fetch-address generator with a circular return-address stack.
// Optional interrupt entry is enabled by defining HYPER_PC_IRQ_EN.
module hyper_pc_unit #(
    parameter int              PC_W        = 16,
    parameter int              PC_INC      = 1,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter int              STACK_DEPTH = 4,
    parameter int              SP_W        = 2
) (
    input  logic      clk,
    input  logic      rst,
    hyper_pc_if.master bus
);
    localparam logic [PC_W-1:0] INC  = PC_W'(PC_INC);
    localparam logic [SP_W:0]   FULL = (SP_W+1)'(STACK_DEPTH);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            vld_q, vld_d;
    logic [SP_W-1:0] sp_q, sp_d, sp_m1;
    logic [SP_W:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push;
    logic [PC_W-1:0] push_val;
    logic [PC_W-1:0] stk_q [STACK_DEPTH];
`ifdef HYPER_PC_IRQ_EN
    logic            ack_q, ack_d;
`endif

    // sp_q is the next write slot; the top of stack sits just below it
    assign sp_m1 = sp_q - 1'b1;

    always_comb begin
        pc_d     = pc_q;
        vld_d    = 1'b1;
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        push_val = pc_q + INC;
`ifdef HYPER_PC_IRQ_EN
        ack_d    = 1'b0;
`endif
        if (vld_q) begin
`ifdef HYPER_PC_IRQ_EN
            if (bus.irq) begin
                push     = 1'b1;
                push_val = pc_q;
                pc_d     = bus.irq_vec;
                ack_d    = 1'b1;
            end else
`endif
            if (bus.ret) begin
                if (cnt_q == '0) begin
                    pc_d  = RESET_VEC;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = stk_q[sp_m1];
                    sp_d  = sp_m1;
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (bus.call) begin
                push = 1'b1;
                pc_d = bus.br_target;
            end else if (bus.br_taken) begin
                pc_d = bus.br_target;
            end else if (bus.fetch_ready) begin
                pc_d = pc_q + INC;
            end
        end
        // A push into a full stack wraps onto the oldest entry
        if (push) begin
            sp_d = sp_q + 1'b1;
            if (cnt_q == FULL) ovf_d = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            vld_q <= 1'b0;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

`ifdef HYPER_PC_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ack_q <= 1'b0;
        else      ack_q <= ack_d;
    end
    assign bus.irq_ack = ack_q;
`endif

    // Stack storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (push) stk_q[sp_q] <= push_val;
    end

    assign bus.pc_out    = pc_q;
    assign bus.pc_valid  = vld_q;
    assign bus.stack_cnt = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
endmodule

// File: tb/tb_hyper_pc_unit.sv
// Directed and random bench for hyper_pc_unit with a queue-based reference model.
// Define HYPER_PC_IRQ_EN to also exercise the interrupt entry.
module tb_hyper_pc_unit;
    localparam int          PC_W  = 16;
    localparam int          SP_W  = 2;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hyper_pc_if #(.PC_W(PC_W), .SP_W(SP_W)) bus ();

    hyper_pc_unit #(
        .PC_W(PC_W), .PC_INC(1), .RESET_VEC(RV), .STACK_DEPTH(DEPTH), .SP_W(SP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] mpc;
    bit          mvld, movf, munf, mack;
    logic [15:0] stk[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mpc = RV; mvld = 0; movf = 0; munf = 0; mack = 0;
        stk.delete();
    endtask

    task automatic model_push(input logic [15:0] v);
        if (stk.size() == DEPTH) begin
            void'(stk.pop_front());
            movf = 1;
        end
        stk.push_back(v);
    endtask

    task automatic model_edge(input bit rdy, input bit br, input bit cl, input bit rt,
                              input logic [15:0] tgt, input bit irq, input logic [15:0] vec);
        mack = 0;
        if (!mvld) begin
            mvld = 1;
        end else if (irq) begin
            model_push(mpc);
            mpc  = vec;
            mack = 1;
        end else if (rt) begin
            if (stk.size() == 0) begin
                mpc  = RV;
                munf = 1;
            end else begin
                mpc = stk.pop_back();
            end
        end else if (cl) begin
            model_push(mpc + 16'd1);
            mpc = tgt;
        end else if (br) begin
            mpc = tgt;
        end else if (rdy) begin
            mpc = mpc + 16'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},  32'(bus.pc_out),    32'(mpc));
        chk({tag, ".vld"}, 32'(bus.pc_valid),  32'(mvld));
        chk({tag, ".cnt"}, 32'(bus.stack_cnt), 32'(stk.size()));
        chk({tag, ".ovf"}, 32'(bus.ovf),       32'(movf));
        chk({tag, ".unf"}, 32'(bus.unf),       32'(munf));
`ifdef HYPER_PC_IRQ_EN
        chk({tag, ".ack"}, 32'(bus.irq_ack),   32'(mack));
`endif
    endtask

    task automatic step_irq(input string tag, input bit rdy, input bit br, input bit cl,
                            input bit rt, input logic [15:0] tgt,
                            input bit irq, input logic [15:0] vec);
        bus.fetch_ready = rdy;
        bus.br_taken    = br;
        bus.call        = cl;
        bus.ret         = rt;
        bus.br_target   = tgt;
`ifdef HYPER_PC_IRQ_EN
        bus.irq         = irq;
        bus.irq_vec     = vec;
`endif
        @(posedge clk);
        model_edge(rdy, br, cl, rt, tgt, irq, vec);
        #1;
        check_all(tag);
    endtask

    task automatic step(input string tag, input bit rdy, input bit br, input bit cl,
                        input bit rt, input logic [15:0] tgt);
        step_irq(tag, rdy, br, cl, rt, tgt, 1'b0, 16'h0000);
    endtask

    initial begin
        rst = 1'b0;
        bus.fetch_ready = 0; bus.br_taken = 0; bus.call = 0; bus.ret = 0;
        bus.br_target = '0;
`ifdef HYPER_PC_IRQ_EN
        bus.irq = 0; bus.irq_vec = '0;
`endif
        model_reset();

        // 1: reset state, release, sequential fetch
        #100;
        check_all("rst");
        chk("rst.pc_const", 32'(bus.pc_out), 32'h0010);
        rst = 1'b1;
        step("first_edge", 1, 1, 0, 0, 16'h0555);
        chk("first_edge.pc_const", 32'(bus.pc_out), 32'h0010);
        step("seq1", 1, 0, 0, 0, 16'h0);
        step("seq2", 1, 0, 0, 0, 16'h0);
        chk("seq2.pc_const", 32'(bus.pc_out), 32'h0012);

        // 2: stall
        step("br20", 0, 1, 0, 0, 16'h0020);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 16'h0);
        chk("stall.pc_const", 32'(bus.pc_out), 32'h0020);
        step("unstall", 1, 0, 0, 0, 16'h0);
        chk("unstall.pc_const", 32'(bus.pc_out), 32'h0021);

        // 3: call / ret
        step("br30", 1, 1, 0, 0, 16'h0030);
        step("call100", 0, 0, 1, 0, 16'h0100);
        chk("call100.cnt_const", 32'(bus.stack_cnt), 32'd1);
        step("f101", 1, 0, 0, 0, 16'h0);
        step("f102", 1, 0, 0, 0, 16'h0);
        step("ret31", 0, 0, 0, 1, 16'h0);
        chk("ret31.pc_const", 32'(bus.pc_out), 32'h0031);

        // 4: overflow and underflow
        for (int i = 0; i < 5; i++) step("ncall", 1, 0, 1, 0, 16'(16'h0200 + i * 16'h0100));
        chk("ncall.cnt_const", 32'(bus.stack_cnt), 32'd4);
        chk("ncall.ovf_const", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 5; i++) step("nret", 1, 0, 0, 1, 16'h0);
        chk("nret.pc_const", 32'(bus.pc_out), 32'(RV));
        chk("nret.unf_const", 32'(bus.unf), 32'd1);

        // 5: call+ret together, br ignored with call, wrap
        step("br4f", 1, 1, 0, 0, 16'h004F);
        step("call60", 1, 1, 1, 0, 16'h0060);
        step("callret", 1, 1, 1, 1, 16'h0070);
        chk("callret.pc_const", 32'(bus.pc_out), 32'h0050);
        step("brffff", 1, 1, 0, 0, 16'hFFFF);
        step("wrap", 1, 0, 0, 0, 16'h0);
        chk("wrap.pc_const", 32'(bus.pc_out), 32'h0000);

`ifdef HYPER_PC_IRQ_EN
        // 6: interrupt beats call
        step("br40", 1, 1, 0, 0, 16'h0040);
        step_irq("irq", 1, 0, 1, 0, 16'h0300, 1'b1, 16'h0200);
        chk("irq.pc_const", 32'(bus.pc_out), 32'h0200);
        step("irq_drop", 1, 0, 0, 0, 16'h0);
        step("irq_ret", 1, 0, 0, 1, 16'h0);
        chk("irq_ret.pc_const", 32'(bus.pc_out), 32'h0040);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            bit rdy, br, cl, rt, irq;
            r   = int'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            br  = (r == 0) || (r == 6);
            cl  = (r == 1) || (r == 2) || (r == 5) || (r == 6);
            rt  = (r == 3) || (r == 4) || (r == 5);
            irq = 1'b0;
`ifdef HYPER_PC_IRQ_EN
            irq = ($urandom_range(0, 31) == 0) && !mack;
`endif
            step_irq("rand", rdy, br, cl, rt, 16'($urandom), irq, 16'($urandom));
        end

        // Mid-operation reset is asynchronous
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst0", 1, 0, 0, 0, 16'h0);
        step("post_rst1", 1, 0, 0, 0, 16'h0);
        step("post_rst_ret", 1, 0, 0, 1, 16'h0);
        chk("post_rst_ret.unf_const", 32'(bus.unf), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hyper_pc_unit.md
Name: hyper_pc_unit

Overview:
Parametrised program-counter and fetch-address generator for hyper_cpu. It replaces the fixed 16-bit PC.
- Generates the fetch address with a valid/ready handshake to instruction memory.
- Accepts branch, call and return redirects from decode.
- Keeps a hardware return-address stack.
- pc_out feeds instruction memory and is exported at the top level for bench observation.

Parameters:
PC_W, 16, PC and address width in bits.
PC_INC, 1, sequential increment added per accepted fetch (modulo 2^PC_W).
RESET_VEC, 0, PC value loaded in reset; also the target on return-stack underflow.
STACK_DEPTH, 4, return-stack entries; power of two, at least 2.
SP_W, 2, log2(STACK_DEPTH).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
fetch_ready  in  1  instruction memory accepts pc_out this cycle.
br_taken  in  1  redirect to br_target.
br_target  in  PC_W  branch/jump destination.
call  in  1  push return address, redirect to br_target.
ret  in  1  pop return address, redirect to it.
pc_out  out  PC_W  current fetch address.
pc_valid  out  1  pc_out is a valid fetch request.
stack_cnt  out  SP_W+1  occupied return-stack entries, 0..STACK_DEPTH.
ovf  out  1  sticky: a call was made with the stack full.
unf  out  1  sticky: a ret was made with the stack empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_out=RESET_VEC, pc_valid=0, stack_cnt=0, ovf=0, unf=0.
  - Stack pointer cleared; stack contents don't-care.
- First rising edge with rst=1: pc_valid goes to 1, pc_out stays at RESET_VEC. pc_valid then remains 1 until the next reset.
- Handshake: a fetch is accepted on any edge with pc_valid=1 and fetch_ready=1.
- Next-PC priority on each edge with pc_valid=1, highest first:
  1. ret:
     - stack non-empty: pc_out <= top entry, stack_cnt decrements.
     - stack empty: pc_out <= RESET_VEC, unf <= 1, stack_cnt stays 0.
  2. call:
     - pushes pc_out+PC_INC (truncated to PC_W), then pc_out <= br_target.
     - stack full: the oldest entry is overwritten (circular), stack_cnt stays at STACK_DEPTH, ovf <= 1.
  3. br_taken: pc_out <= br_target.
  4. accepted fetch: pc_out <= pc_out+PC_INC, wrapping modulo 2^PC_W.
  5. otherwise pc_out holds (stall).
- Redirects (1–3) take effect at the next edge regardless of fetch_ready. The unaccepted current fetch is abandoned and no increment occurs in that cycle.
- Simultaneous call and ret: ret wins, call is ignored (no push, no ovf).
- br_taken together with call or ret is ignored.
- Latency: every redirect appears on pc_out exactly one edge after its request is sampled.
- Redirect inputs sampled while pc_valid=0 (the first cycle after reset) are ignored.
- ovf and unf clear only on reset.
- Reset asserted mid-operation immediately forces all reset values, including an empty stack.

Optional Feature:
Macro HYPER_PC_IRQ_EN.
- Defined: adds ports irq (in, 1), irq_vec (in, PC_W) and irq_ack (out, 1, reset 0).
  - irq=1 on an edge with pc_valid=1 has priority over all redirects.
  - It pushes pc_out (the interrupted, not-yet-executed address) using the same full-stack rule as call.
  - pc_out <= irq_vec.
  - irq_ack pulses high for exactly one cycle.
  - irq is level-sensitive; the source must drop it after irq_ack.
- Not defined: no extra ports and behaviour exactly as above.

Test Plan:
1. Hold rst=0 for 100 ns with RESET_VEC=16'h0010 -> pc_out=0010, pc_valid=0. Release rst -> pc_valid=1 next edge. With fetch_ready=1 held, pc_out steps 0010, 0011, 0012.
2. fetch_ready=0 for 3 cycles at pc_out=0020 -> pc_out holds 0020. Raise fetch_ready -> 0021.
3. At pc_out=0030, assert call with br_target=0100 -> pc_out=0100, stack_cnt=1. Run to 0102, assert ret -> pc_out=0031, stack_cnt=0.
4. With STACK_DEPTH=4, issue 5 nested calls -> stack_cnt=4, ovf=1. Then 5 rets -> first four return the newest four addresses in reverse order; the fifth goes to RESET_VEC with unf=1.
5. Assert call and ret together with the stack holding 0050 -> pc_out=0050, no push. Then br_taken with target FFFF, then accepted fetch -> pc_out FFFF then 0000 (wrap).
6. With HYPER_PC_IRQ_EN defined, irq=1 and irq_vec=0200 at pc_out=0040 with call also asserted -> pc_out=0200, stack top=0040, irq_ack high one cycle, call ignored. A later ret -> 0040.
